// File: rtl/dpr_pkg.sv
// Shared encodings for the dual-port RAM with clear engine.
package dpr_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   // Same-port read-during-write modes
   localparam int unsigned WF_NEW = 1;
   localparam int unsigned WF_OLD = 0;

endpackage

// File: rtl/dpr_clr_if.sv
// Bus bundle for both RAM ports plus the clear/busy handshake.
interface dpr_clr_if #(
   parameter int unsigned AW = 14,
   parameter int unsigned DW = 8
);
   logic          clear;
   logic          busy;
   logic [AW-1:0] a1;
   logic [DW-1:0] d1;
   logic          w1;
   logic [DW-1:0] q1;
   logic [AW-1:0] a2;
   logic [DW-1:0] d2;
   logic          w2;
   logic [DW-1:0] q2;

   modport master (
      output clear, a1, d1, w1, a2, d2, w2,
      input  busy, q1, q2
   );

   modport slave (
      input  clear, a1, d1, w1, a2, d2, w2,
      output busy, q1, q2
   );
endinterface

// File: rtl/dpr_sweep.sv
// Clear engine: walks every address once, driving a fill write each cycle.
module dpr_sweep
   import dpr_pkg::*;
#(
   parameter int unsigned AW           = 14,
   parameter bit          CLR_ON_RESET = 1'b1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   output logic [AW-1:0] sweep_addr,
   output logic          sweep_we,
   output logic          busy
);

   state_t        state;
   logic [AW-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= CLR_ON_RESET ? ST_SWEEP : ST_IDLE;
         cnt   <= '0;
         busy  <= CLR_ON_RESET;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clear) begin
                  state <= ST_SWEEP;
                  busy  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               cnt <= cnt + 1'b1;
               // Last address written on this edge; counter wraps back to 0
               if (cnt == '1) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sweep_addr = cnt;
   assign sweep_we   = (state == ST_SWEEP);

endmodule

// File: rtl/dpr_clr.sv
// True dual-port RAM with registered reads and a self-clearing sweep on port 2.
module dpr_clr
   import dpr_pkg::*;
#(
   parameter int unsigned   AW           = 14,
   parameter int unsigned   DW           = 8,
   parameter int unsigned   WF           = WF_NEW,
   parameter logic [DW-1:0] FILL         = '0,
   parameter bit            CLR_ON_RESET = 1'b1
) (
   input logic       clock,
   input logic       reset,
   dpr_clr_if.slave  bus
);

   logic [DW-1:0] mem [2**AW];

   logic [AW-1:0] sweep_addr;
   logic          sweep_we;
   logic          busy;

   logic          we1;
   logic          we2;
   logic [AW-1:0] wa2;
   logic [DW-1:0] wd2;
   logic [DW-1:0] q1;
   logic [DW-1:0] q2;

   dpr_sweep #(
      .AW           (AW),
      .CLR_ON_RESET (CLR_ON_RESET)
   ) u_sweep (
      .clock      (clock),
      .reset      (reset),
      .clear      (bus.clear),
      .sweep_addr (sweep_addr),
      .sweep_we   (sweep_we),
      .busy       (busy)
   );

   // The sweep borrows port 2's write path; port 2 wins any address collision
   always_comb begin
      we2 = sweep_we | bus.w2;
      wa2 = sweep_we ? sweep_addr : bus.a2;
      wd2 = sweep_we ? FILL : bus.d2;
      we1 = bus.w1 & ~(we2 & (bus.a1 == wa2));
   end

   always_ff @(posedge clock) begin
      if (we1) mem[bus.a1] <= bus.d1;
      if (we2) mem[wa2]    <= wd2;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q1 <= '0;
         q2 <= '0;
      end else begin
         if (we1 && (WF == WF_NEW)) q1 <= bus.d1;
         else                       q1 <= mem[bus.a1];
         // Port 2 is owned by the sweep while busy, so its read register holds
         if (!sweep_we) begin
            if (bus.w2 && (WF == WF_NEW)) q2 <= bus.d2;
            else                          q2 <= mem[bus.a2];
         end
      end
   end

   assign bus.busy = busy;
   assign bus.q1   = q1;
   assign bus.q2   = q2;

endmodule

// File: tb/tb_dpr_clr.sv
// Directed bench for dpr_clr: write-through and old-data instances share one stimulus.
module tb_dpr_clr;

   localparam int unsigned AW   = 4;
   localparam int unsigned DW   = 8;
   localparam logic [7:0]  FILL = 8'hA5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dpr_clr_if #(.AW(AW), .DW(DW)) bus ();
   dpr_clr_if #(.AW(AW), .DW(DW)) bus_o ();

   assign bus_o.clear = bus.clear;
   assign bus_o.a1    = bus.a1;
   assign bus_o.d1    = bus.d1;
   assign bus_o.w1    = bus.w1;
   assign bus_o.a2    = bus.a2;
   assign bus_o.d2    = bus.d2;
   assign bus_o.w2    = bus.w2;

   dpr_clr #(
      .AW(AW), .DW(DW), .WF(1), .FILL(FILL), .CLR_ON_RESET(1'b1)
   ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   dpr_clr #(
      .AW(AW), .DW(DW), .WF(0), .FILL(FILL), .CLR_ON_RESET(1'b1)
   ) u_dut_old (
      .clock (clock),
      .reset (reset),
      .bus   (bus_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n;
   logic [7:0] exp_mem [16];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.clear = 1'b0;
      bus.w1    = 1'b0;
      bus.w2    = 1'b0;
      bus.d1    = '0;
      bus.d2    = '0;
   endtask

   initial begin
      idle_inputs();
      bus.a1 = '0;
      bus.a2 = '0;
      reset  = 1'b1;
      tick();
      tick();
      chk("reset q1", bus.q1, 8'h00);
      chk("reset q2", bus.q2, 8'h00);
      chk("reset busy", {7'b0, bus.busy}, 8'h01);

      // Automatic sweep after reset release
      reset = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.busy && n < 40);
      chk("reset sweep length", 8'(n), 8'd16);
      chk("old dut idle", {7'b0, bus_o.busy}, 8'h00);

      for (int i = 0; i < 16; i++) begin
         bus.a1 = AW'(i);
         tick();
         chk("post reset fill", bus.q1, FILL);
      end

      // Same-port write, both read-during-write modes
      bus.a1 = 4'd3; bus.d1 = 8'h12; bus.w1 = 1'b1;
      tick();
      chk("wf new q1", bus.q1, 8'h12);
      chk("wf old q1", bus_o.q1, FILL);
      bus.w1 = 1'b0; bus.a2 = 4'd3;
      tick();
      chk("port2 readback", bus.q2, 8'h12);
      chk("port2 readback old", bus_o.q2, 8'h12);

      // Write collision: port 2 data wins
      bus.a1 = 4'd7; bus.d1 = 8'h11; bus.w1 = 1'b1;
      bus.a2 = 4'd7; bus.d2 = 8'h22; bus.w2 = 1'b1;
      tick();
      idle_inputs();
      tick();
      chk("collision", bus.q1, 8'h22);

      // Mixed-port read while the other port writes
      bus.a1 = 4'd9;
      bus.a2 = 4'd9; bus.d2 = 8'h5A; bus.w2 = 1'b1;
      tick();
      chk("mixed old", bus.q1, FILL);
      chk("wf new q2", bus.q2, 8'h5A);
      chk("wf old q2", bus_o.q2, FILL);
      bus.w2 = 1'b0;
      tick();
      chk("mixed later", bus.q1, 8'h5A);

      // Commanded sweep with ignored re-clear, ignored w2 and port 1 traffic
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("clear busy", {7'b0, bus.busy}, 8'h01);
      n = 0;
      do begin
         n++;
         idle_inputs();
         if (n == 5) bus.clear = 1'b1;
         if (n == 10) begin bus.a2 = 4'd2; bus.d2 = 8'h77; bus.w2 = 1'b1; end
         if (n == 12) begin bus.a1 = 4'd14; bus.d1 = 8'h3C; bus.w1 = 1'b1; end
         if (n == 13) begin bus.a1 = 4'd1; bus.d1 = 8'h4B; bus.w1 = 1'b1; end
         tick();
         if (n == 10) chk("q2 held in sweep", bus.q2, 8'h5A);
      end while (bus.busy && n < 40);
      idle_inputs();
      chk("clear sweep length", 8'(n), 8'd16);

      for (int i = 0; i < 16; i++) exp_mem[i] = FILL;
      exp_mem[1] = 8'h4B;
      for (int i = 0; i < 16; i++) begin
         bus.a1 = AW'(i);
         tick();
         chk("post clear contents", bus.q1, exp_mem[i]);
      end

      // Reset in the middle of a sweep
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      repeat (8) tick();
      reset = 1'b1;
      #1;
      chk("mid reset q1", bus.q1, 8'h00);
      chk("mid reset q2", bus.q2, 8'h00);
      chk("mid reset busy", {7'b0, bus.busy}, 8'h01);
      tick();
      reset = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.busy && n < 40);
      chk("restart sweep length", 8'(n), 8'd16);

      for (int i = 0; i < 16; i++) begin
         bus.a1 = AW'(i);
         tick();
         chk("post restart fill", bus.q1, FILL);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
